// File: rtl/gba_io_pkg.sv
// rtl/gba_io_pkg.sv - shared widths, state encoding and byte-lane helpers for the compact BRAM path
package gba_io_pkg;

    localparam logic [1:0] DATA_WIDTH_0  = 2'b00;
    localparam logic [1:0] DATA_WIDTH_8  = 2'b01;
    localparam logic [1:0] DATA_WIDTH_16 = 2'b10;
    localparam logic [1:0] DATA_WIDTH_32 = 2'b11;

    localparam int unsigned COMPACT_BRAM_SIZE_DEFAULT = 32'h62080;

    localparam logic [15:0] CART_ERR_DATA = 16'hDEAD;
    localparam logic [31:0] USB_ERR_DATA  = 32'hDEADBEEF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_XLATE,
        ST_MEM,
        ST_RESP
    } state_t;

    // Byte a of a word lives in bits [31-8a -: 8], i.e. a right shift by 8*(3-a).
    function automatic logic [7:0] byte_sel(input logic [31:0] w, input logic [1:0] a);
        return 8'(w >> {~a, 3'b000});
    endfunction

    function automatic logic [15:0] cart_rd_fmt(input logic [31:0] w, input logic [1:0] a,
                                                input logic [1:0] width);
        case (width)
            DATA_WIDTH_8:  return {8'h00, byte_sel(w, a)};
            DATA_WIDTH_16: return {byte_sel(w, {a[1], 1'b1}), byte_sel(w, {a[1], 1'b0})};
            default:       return CART_ERR_DATA;
        endcase
    endfunction

    // Write enable bit 3 covers byte 0 ([31:24]), so byte a maps to bit 3-a.
    function automatic logic [3:0] cart_we(input logic [1:0] a, input logic [1:0] width);
        case (width)
            DATA_WIDTH_8:  return 4'b1000 >> a;
            DATA_WIDTH_16: return a[1] ? 4'b0011 : 4'b1100;
            default:       return 4'b0000;
        endcase
    endfunction

    // 16-bit writes put the low byte in the even lane and the high byte in the odd lane.
    function automatic logic [31:0] cart_wdata(input logic [15:0] d, input logic [1:0] width);
        if (width == DATA_WIDTH_8)
            return {4{d[7:0]}};
        return {d[7:0], d[15:8], d[7:0], d[15:8]};
    endfunction

endpackage

// File: rtl/compact_bram.sv
// rtl/compact_bram.sv - single-port byte-enabled block RAM, 1-cycle read latency
module compact_bram
    import gba_io_pkg::*;
#(
    parameter int          WORD_AW = 17,
    parameter int unsigned DEPTH   = COMPACT_BRAM_SIZE_DEFAULT / 4
) (
    input  logic               clk,
    input  logic               en,
    input  logic [3:0]         we,
    input  logic [WORD_AW-1:0] addr,
    input  logic [31:0]        wdata,
    output logic [31:0]        rdata
);

    logic [31:0] mem [DEPTH];

    // Read-before-write port; addresses past the end are ignored.
    always_ff @(posedge clk) begin
        if (en && (32'(addr) < DEPTH)) begin
            for (int b = 0; b < 4; b++) begin
                if (we[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
            end
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/bram_arbiter.sv
// rtl/bram_arbiter.sv - cart/USB sequencer and arbiter for the shared compact BRAM
module bram_arbiter
    import gba_io_pkg::*;
#(
    parameter int unsigned COMPACT_BRAM_SIZE = COMPACT_BRAM_SIZE_DEFAULT,
    parameter int          WORD_AW           = 17,
    parameter int          USB_MAX_WAIT      = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cart_rd,
    input  logic               cart_wr,
    input  logic [25:0]        cart_addr,
    input  logic [1:0]         cart_data_width,
    input  logic [15:0]        cart_wr_data,
    output logic [15:0]        cart_rd_data,
    output logic               cart_rd_valid,
    output logic               cart_wr_ready,
    input  logic               usb_rd,
    input  logic               usb_wr,
    input  logic [25:0]        usb_addr,
    input  logic [31:0]        usb_wr_data,
    output logic [31:0]        usb_rd_data,
    output logic               usb_rd_valid,
    output logic               usb_wr_ready,
    output logic               from_cart,
    output logic               from_usb,
    output logic [25:0]        cart_usb_addr,
    input  logic [18:0]        compact_addr,
    output logic               bram_en,
    output logic [3:0]         bram_we,
    output logic [WORD_AW-1:0] bram_addr,
    output logic [31:0]        bram_wdata,
    input  logic [31:0]        bram_rdata,
    output logic [1:0]         ovf,
    output logic               oor
);

    localparam logic [7:0] MAX_WAIT = 8'(USB_MAX_WAIT);

    state_t      state;
    logic        cart_pend, usb_pend;
    logic [25:0] cart_addr_q, usb_addr_q;
    logic [15:0] cart_wdata_q;
    logic [31:0] usb_wdata_q;
    logic [1:0]  cart_width_q;
    logic        cart_isrd_q, usb_isrd_q;
    logic        serv_usb, serv_rd, serv_oor;
    logic [1:0]  serv_width, serv_off;
    logic [31:0] serv_wdata;
    logic [7:0]  starve;

    logic        cart_take, usb_take, cart_drop, usb_drop;
    logic        cart_req, usb_req, grant_usb, grant_cart, addr_oor;
    logic [25:0] cart_addr_cur, usb_addr_cur;
    logic [15:0] cart_wdata_cur;
    logic [31:0] usb_wdata_cur;
    logic [1:0]  cart_width_cur;
    logic        cart_rd_cur, usb_rd_cur;

    // Request acceptance and arbitration; a fresh pulse can be granted in the cycle it arrives.
    always_comb begin
        cart_take      = (cart_rd | cart_wr) & ~cart_pend;
        usb_take       = (usb_rd | usb_wr) & ~usb_pend;
        cart_drop      = ((cart_rd | cart_wr) & cart_pend) | (cart_rd & cart_wr);
        usb_drop       = ((usb_rd | usb_wr) & usb_pend) | (usb_rd & usb_wr);
        cart_req       = cart_pend | cart_take;
        usb_req        = usb_pend | usb_take;
        grant_usb      = usb_req & (~cart_req | (starve == MAX_WAIT));
        grant_cart     = cart_req & ~grant_usb;
        cart_addr_cur  = cart_pend ? cart_addr_q  : cart_addr;
        cart_wdata_cur = cart_pend ? cart_wdata_q : cart_wr_data;
        cart_width_cur = cart_pend ? cart_width_q : cart_data_width;
        cart_rd_cur    = cart_pend ? cart_isrd_q  : cart_rd;
        usb_addr_cur   = usb_pend  ? usb_addr_q   : usb_addr;
        usb_wdata_cur  = usb_pend  ? usb_wdata_q  : usb_wr_data;
        usb_rd_cur     = usb_pend  ? usb_isrd_q   : usb_rd;
        addr_oor       = 32'(compact_addr) >= COMPACT_BRAM_SIZE;
    end

    // Latch request details for a source that has to wait behind the other one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cart_addr_q  <= '0;
            cart_wdata_q <= '0;
            cart_width_q <= '0;
            cart_isrd_q  <= 1'b0;
            usb_addr_q   <= '0;
            usb_wdata_q  <= '0;
            usb_isrd_q   <= 1'b0;
        end else begin
            if (cart_take) begin
                cart_addr_q  <= cart_addr;
                cart_wdata_q <= cart_wr_data;
                cart_width_q <= cart_data_width;
                cart_isrd_q  <= cart_rd;
            end
            if (usb_take) begin
                usb_addr_q  <= usb_addr;
                usb_wdata_q <= usb_wr_data;
                usb_isrd_q  <= usb_rd;
            end
        end
    end

    // Transaction sequencer: IDLE -> XLATE -> MEM -> (RESP) -> IDLE, all outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            cart_pend     <= 1'b0;
            usb_pend      <= 1'b0;
            starve        <= '0;
            serv_usb      <= 1'b0;
            serv_rd       <= 1'b0;
            serv_oor      <= 1'b0;
            serv_width    <= '0;
            serv_off      <= '0;
            serv_wdata    <= '0;
            cart_rd_data  <= '0;
            cart_rd_valid <= 1'b0;
            cart_wr_ready <= 1'b0;
            usb_rd_data   <= '0;
            usb_rd_valid  <= 1'b0;
            usb_wr_ready  <= 1'b0;
            from_cart     <= 1'b0;
            from_usb      <= 1'b0;
            cart_usb_addr <= '0;
            bram_en       <= 1'b0;
            bram_we       <= '0;
            bram_addr     <= '0;
            bram_wdata    <= '0;
            ovf           <= '0;
            oor           <= 1'b0;
        end else begin
            cart_rd_valid <= 1'b0;
            cart_wr_ready <= 1'b0;
            usb_rd_valid  <= 1'b0;
            usb_wr_ready  <= 1'b0;
            from_cart     <= 1'b0;
            from_usb      <= 1'b0;
            bram_en       <= 1'b0;
            bram_we       <= '0;
            ovf           <= ovf | {usb_drop, cart_drop};
            if (cart_take) cart_pend <= 1'b1;
            if (usb_take)  usb_pend  <= 1'b1;
            case (state)
                ST_IDLE: begin
                    if (grant_usb) begin
                        from_usb      <= 1'b1;
                        cart_usb_addr <= usb_addr_cur;
                        serv_usb      <= 1'b1;
                        serv_rd       <= usb_rd_cur;
                        serv_width    <= DATA_WIDTH_32;
                        serv_wdata    <= usb_wdata_cur;
                        starve        <= '0;
                        state         <= ST_XLATE;
                    end else if (grant_cart) begin
                        from_cart     <= 1'b1;
                        cart_usb_addr <= cart_addr_cur;
                        serv_usb      <= 1'b0;
                        serv_rd       <= cart_rd_cur;
                        serv_width    <= cart_width_cur;
                        serv_wdata    <= {16'h0000, cart_wdata_cur};
                        if (usb_req && (starve != MAX_WAIT)) starve <= starve + 8'd1;
                        state         <= ST_XLATE;
                    end
                end
                ST_XLATE: begin
                    serv_off  <= compact_addr[1:0];
                    serv_oor  <= addr_oor;
                    if (addr_oor) oor <= 1'b1;
                    bram_en   <= 1'b1;
                    bram_addr <= WORD_AW'(compact_addr[18:2]);
                    if (!serv_rd) begin
                        bram_wdata <= serv_usb ? serv_wdata : cart_wdata(serv_wdata[15:0], serv_width);
                        if (!addr_oor)
                            bram_we <= serv_usb ? 4'hF : cart_we(compact_addr[1:0], serv_width);
                    end
                    state <= ST_MEM;
                end
                ST_MEM: begin
                    if (serv_rd) begin
                        state <= ST_RESP;
                    end else begin
                        if (serv_usb) begin
                            usb_wr_ready <= 1'b1;
                            usb_pend     <= 1'b0;
                        end else begin
                            cart_wr_ready <= 1'b1;
                            cart_pend     <= 1'b0;
                        end
                        state <= ST_IDLE;
                    end
                end
                ST_RESP: begin
                    if (serv_usb) begin
                        usb_rd_data  <= serv_oor ? USB_ERR_DATA : bram_rdata;
                        usb_rd_valid <= 1'b1;
                        usb_pend     <= 1'b0;
                    end else begin
                        cart_rd_data  <= serv_oor ? CART_ERR_DATA
                                                  : cart_rd_fmt(bram_rdata, serv_off, serv_width);
                        cart_rd_valid <= 1'b1;
                        cart_pend     <= 1'b0;
                    end
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bram_arbiter.sv
// tb/tb_bram_arbiter.sv - self-checking bench for bram_arbiter with compact_bram and an identity address buffer
module tb_bram_arbiter;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cart_rd = 0, cart_wr = 0, usb_rd = 0, usb_wr = 0;
    logic [25:0] cart_addr = '0, usb_addr = '0;
    logic [1:0]  cart_data_width = '0;
    logic [15:0] cart_wr_data = '0;
    logic [31:0] usb_wr_data = '0;
    logic [15:0] cart_rd_data;
    logic [31:0] usb_rd_data, bram_wdata, bram_rdata;
    logic        cart_rd_valid, cart_wr_ready, usb_rd_valid, usb_wr_ready;
    logic        from_cart, from_usb, bram_en, oor;
    logic [25:0] cart_usb_addr;
    logic [18:0] compact_addr;
    logic [3:0]  bram_we;
    logic [16:0] bram_addr;
    logic [1:0]  ovf;

    int passed = 0;
    int checks = 0;
    logic [15:0] exp_cart[$];
    logic [31:0] exp_usb[$];
    logic [3:0]  last_we = '0;
    int          n_from_cart = 0;
    int          cart_at_usb = 0;

    always #5 clk = ~clk;

    assign compact_addr = cart_usb_addr[18:0];

    wire [136:0] all_out = {cart_rd_data, cart_rd_valid, cart_wr_ready, usb_rd_data, usb_rd_valid,
                            usb_wr_ready, from_cart, from_usb, cart_usb_addr, bram_en, bram_we,
                            bram_addr, bram_wdata, ovf, oor};

    bram_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .cart_rd(cart_rd), .cart_wr(cart_wr), .cart_addr(cart_addr),
        .cart_data_width(cart_data_width), .cart_wr_data(cart_wr_data),
        .cart_rd_data(cart_rd_data), .cart_rd_valid(cart_rd_valid), .cart_wr_ready(cart_wr_ready),
        .usb_rd(usb_rd), .usb_wr(usb_wr), .usb_addr(usb_addr), .usb_wr_data(usb_wr_data),
        .usb_rd_data(usb_rd_data), .usb_rd_valid(usb_rd_valid), .usb_wr_ready(usb_wr_ready),
        .from_cart(from_cart), .from_usb(from_usb), .cart_usb_addr(cart_usb_addr),
        .compact_addr(compact_addr), .bram_en(bram_en), .bram_we(bram_we),
        .bram_addr(bram_addr), .bram_wdata(bram_wdata), .bram_rdata(bram_rdata),
        .ovf(ovf), .oor(oor)
    );

    compact_bram u_bram (
        .clk(clk), .en(bram_en), .we(bram_we), .addr(bram_addr),
        .wdata(bram_wdata), .rdata(bram_rdata)
    );

    always @(negedge clk) begin
        if (bram_en) last_we <= bram_we;
        if (from_cart) n_from_cart <= n_from_cart + 1;
        if (from_usb) cart_at_usb <= n_from_cart;
    end

    task automatic drive(input logic crd, input logic cwr, input logic [25:0] ca, input logic [1:0] cw,
                         input logic [15:0] cd, input logic urd, input logic uwr,
                         input logic [25:0] ua, input logic [31:0] ud);
        cart_rd = crd; cart_wr = cwr; cart_addr = ca; cart_data_width = cw; cart_wr_data = cd;
        usb_rd = urd; usb_wr = uwr; usb_addr = ua; usb_wr_data = ud;
        @(posedge clk); #1;
        cart_rd = 0; cart_wr = 0; usb_rd = 0; usb_wr = 0;
    endtask

    // sel: 0 cart_rd_valid, 1 cart_wr_ready, 2 usb_rd_valid, 3 usb_wr_ready; cyc = -1 on timeout
    task automatic wait_sig(input int sel, output int cyc);
        logic s;
        cyc = -1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            case (sel)
                0: s = cart_rd_valid;
                1: s = cart_wr_ready;
                2: s = usb_rd_valid;
                default: s = usb_wr_ready;
            endcase
            if (s) begin cyc = i; break; end
        end
    endtask

    task automatic test_reset;
        checks++; if (all_out !== '0) $display("FAIL reset_outputs: got %h want 0", all_out); else passed++;
        @(posedge clk); #1; rst_n = 1'b1;
        @(posedge clk); #1;
        checks++; if (all_out !== '0) $display("FAIL idle_outputs: got %h want 0", all_out); else passed++;
    endtask

    task automatic test_usb_round_trip;
        int c; logic [31:0] e;
        drive(0, 0, 0, 0, 0, 0, 1, 26'd0, 32'h11223344);
        wait_sig(3, c);
        checks++; if (c !== 2) $display("FAIL usb_wr_latency: got %0d want 2", c); else passed++;
        checks++; if (last_we !== 4'hF) $display("FAIL usb_we: got %h want f", last_we); else passed++;
        drive(0, 0, 0, 0, 0, 0, 1, 26'd20, 32'hCAFEF00D);
        wait_sig(3, c);
        exp_usb.push_back(32'hCAFEF00D);
        drive(0, 0, 0, 0, 0, 1, 0, 26'd20, 0);
        wait_sig(2, c);
        checks++; if (c !== 3) $display("FAIL usb_rd_latency: got %0d want 3", c); else passed++;
        e = exp_usb.pop_front();
        checks++; if (usb_rd_data !== e) $display("FAIL usb_rd_data: got %h want %h", usb_rd_data, e); else passed++;
    endtask

    task automatic test_cart_read16;
        int c; logic [15:0] e;
        exp_cart.push_back(16'h2211);
        drive(1, 0, 26'd0, 2'b10, 0, 0, 0, 0, 0);
        wait_sig(0, c);
        checks++; if (c !== 3) $display("FAIL cart_rd_latency: got %0d want 3", c); else passed++;
        e = exp_cart.pop_front();
        checks++; if (cart_rd_data !== e) $display("FAIL cart_rd16: got %h want %h", cart_rd_data, e); else passed++;
    endtask

    task automatic test_cart_write_read;
        int c; logic [15:0] e;
        drive(0, 1, 26'd2, 2'b01, 16'h00A5, 0, 0, 0, 0);
        wait_sig(1, c);
        checks++; if (c !== 2) $display("FAIL cart_wr_latency: got %0d want 2", c); else passed++;
        checks++; if (last_we !== 4'b0010) $display("FAIL cart_we8: got %b want 0010", last_we); else passed++;
        exp_cart.push_back(16'h00A5);
        drive(1, 0, 26'd2, 2'b01, 0, 0, 0, 0, 0);
        wait_sig(0, c);
        e = exp_cart.pop_front();
        checks++; if (cart_rd_data !== e) $display("FAIL cart_rd8: got %h want %h", cart_rd_data, e); else passed++;
        exp_cart.push_back(16'h44A5);
        drive(1, 0, 26'd3, 2'b10, 0, 0, 0, 0, 0);
        wait_sig(0, c);
        e = exp_cart.pop_front();
        checks++; if (cart_rd_data !== e) $display("FAIL cart_rd16_hi: got %h want %h", cart_rd_data, e); else passed++;
        drive(0, 1, 26'd4, 2'b10, 16'hBEEF, 0, 0, 0, 0);
        wait_sig(1, c);
        checks++; if (last_we !== 4'b1100) $display("FAIL cart_we16: got %b want 1100", last_we); else passed++;
        exp_cart.push_back(16'hBEEF);
        drive(1, 0, 26'd4, 2'b10, 0, 0, 0, 0, 0);
        wait_sig(0, c);
        e = exp_cart.pop_front();
        checks++; if (cart_rd_data !== e) $display("FAIL cart_rd16_beef: got %h want %h", cart_rd_data, e); else passed++;
    endtask

    task automatic test_width_err;
        int c; logic [15:0] e;
        exp_cart.push_back(16'hDEAD);
        drive(1, 0, 26'd0, 2'b11, 0, 0, 0, 0, 0);
        wait_sig(0, c);
        e = exp_cart.pop_front();
        checks++; if (cart_rd_data !== e) $display("FAIL width11_rd: got %h want %h", cart_rd_data, e); else passed++;
        drive(0, 1, 26'd0, 2'b00, 16'h1234, 0, 0, 0, 0);
        wait_sig(1, c);
        checks++; if (c !== 2) $display("FAIL width00_ack: got %0d want 2", c); else passed++;
        checks++; if (last_we !== 4'b0000) $display("FAIL width00_we: got %b want 0000", last_we); else passed++;
    endtask

    task automatic test_oor;
        int c; logic [31:0] e;
        checks++; if (oor !== 1'b0) $display("FAIL oor_clear: got %b want 0", oor); else passed++;
        drive(0, 1, 26'h62080, 2'b01, 16'h0077, 0, 0, 0, 0);
        wait_sig(1, c);
        checks++; if (c !== 2) $display("FAIL oor_ack: got %0d want 2", c); else passed++;
        checks++; if (last_we !== 4'b0000) $display("FAIL oor_we: got %b want 0000", last_we); else passed++;
        checks++; if (oor !== 1'b1) $display("FAIL oor_set: got %b want 1", oor); else passed++;
        exp_usb.push_back(32'hDEADBEEF);
        drive(0, 0, 0, 0, 0, 1, 0, 26'h62080, 0);
        wait_sig(2, c);
        e = exp_usb.pop_front();
        checks++; if (usb_rd_data !== e) $display("FAIL oor_usb_rd: got %h want %h", usb_rd_data, e); else passed++;
    endtask

    task automatic test_ovf;
        int c; logic [15:0] e; logic [31:0] eu;
        exp_cart.push_back(16'h2211);
        drive(1, 0, 26'd0, 2'b10, 0, 0, 0, 0, 0);
        drive(1, 0, 26'd4, 2'b10, 0, 0, 0, 0, 0);
        wait_sig(0, c);
        e = exp_cart.pop_front();
        checks++; if (cart_rd_data !== e) $display("FAIL ovf_first_rd: got %h want %h", cart_rd_data, e); else passed++;
        checks++; if (ovf !== 2'b01) $display("FAIL ovf_cart: got %b want 01", ovf); else passed++;
        wait_sig(0, c);
        checks++; if (c !== -1) $display("FAIL ovf_dropped: got valid after %0d want none", c); else passed++;
        exp_usb.push_back(32'hCAFEF00D);
        drive(0, 0, 0, 0, 0, 1, 1, 26'd20, 32'h12345678);
        wait_sig(2, c);
        eu = exp_usb.pop_front();
        checks++; if (usb_rd_data !== eu) $display("FAIL rdwr_read_wins: got %h want %h", usb_rd_data, eu); else passed++;
        checks++; if (ovf !== 2'b11) $display("FAIL ovf_usb: got %b want 11", ovf); else passed++;
    endtask

    task automatic test_simultaneous;
        int c; logic [15:0] e; logic [31:0] eu;
        exp_cart.push_back(16'h2211);
        exp_usb.push_back(32'hCAFEF00D);
        drive(1, 0, 26'd0, 2'b10, 0, 1, 0, 26'd20, 0);
        wait_sig(0, c);
        checks++; if (c !== 3) $display("FAIL simul_cart_first: got %0d want 3", c); else passed++;
        e = exp_cart.pop_front();
        checks++; if (cart_rd_data !== e) $display("FAIL simul_cart_rd: got %h want %h", cart_rd_data, e); else passed++;
        wait_sig(2, c);
        checks++; if (c !== 4) $display("FAIL simul_usb_next: got %0d want 4", c); else passed++;
        eu = exp_usb.pop_front();
        checks++; if (usb_rd_data !== eu) $display("FAIL simul_usb_rd: got %h want %h", usb_rd_data, eu); else passed++;
    endtask

    task automatic test_starvation;
        int c; int snap; logic [31:0] eu;
        snap = n_from_cart;
        exp_usb.push_back(32'hCAFEF00D);
        drive(0, 1, 26'd0, 2'b00, 0, 1, 0, 26'd20, 0);
        for (int i = 0; i < 4; i++) begin
            wait_sig(1, c);
            checks++; if (c !== 2) $display("FAIL starve_cart_ack%0d: got %0d want 2", i, c); else passed++;
            drive(0, 1, 26'd0, 2'b00, 0, 0, 0, 0, 0);
        end
        wait_sig(2, c);
        checks++; if (c !== 3) $display("FAIL starve_usb_lat: got %0d want 3", c); else passed++;
        checks++; if (cart_at_usb - snap !== 4) $display("FAIL starve_grants: got %0d want 4", cart_at_usb - snap); else passed++;
        eu = exp_usb.pop_front();
        checks++; if (usb_rd_data !== eu) $display("FAIL starve_usb_rd: got %h want %h", usb_rd_data, eu); else passed++;
        wait_sig(1, c);
        checks++; if (c !== 3) $display("FAIL starve_cart_after: got %0d want 3", c); else passed++;
    endtask

    task automatic test_reset_mid;
        int c; logic [15:0] e;
        drive(0, 0, 0, 0, 0, 0, 1, 26'd8, 32'h00000000);
        wait_sig(3, c);
        drive(0, 1, 26'd8, 2'b01, 16'h005A, 0, 0, 0, 0);
        @(posedge clk); #1;
        checks++; if (bram_en !== 1'b1) $display("FAIL mid_in_mem: got %b want 1", bram_en); else passed++;
        rst_n = 1'b0;
        #1;
        checks++; if (all_out !== '0) $display("FAIL mid_reset_outputs: got %h want 0", all_out); else passed++;
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        wait_sig(1, c);
        checks++; if (c !== -1) $display("FAIL mid_no_ack: got ack after %0d want none", c); else passed++;
        checks++; if ({ovf, oor} !== 3'b000) $display("FAIL mid_flags: got %b want 000", {ovf, oor}); else passed++;
        exp_cart.push_back(16'h0000);
        drive(1, 0, 26'd8, 2'b01, 0, 0, 0, 0, 0);
        wait_sig(0, c);
        checks++; if (c !== 3) $display("FAIL mid_next_lat: got %0d want 3", c); else passed++;
        e = exp_cart.pop_front();
        checks++; if (cart_rd_data !== e) $display("FAIL mid_no_write: got %h want %h", cart_rd_data, e); else passed++;
    endtask

    initial begin
        @(posedge clk); @(posedge clk); #1;
        test_reset;
        test_usb_round_trip;
        test_cart_read16;
        test_cart_write_read;
        test_width_err;
        test_oor;
        test_ovf;
        test_simultaneous;
        test_starvation;
        test_reset_mid;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
